spi_master: RTL

Mode-3 (CPOL=1, CPHA=1) SPI master sitting directly downstream of the accelerometer sequencer. It consumes the sequencer's word/length/request handshake, shifts 1..32 bits MSB-first to the sensor, and returns the received bits right-aligned with ready asserted. It drives the board SPI pins (CSn, SCLK, MOSI) and samples MISO.

---
 rtl/spi_master.sv | 126 ++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// Mode-3 SPI master: shifts 1..32 bits MSB-first and returns the received
// bits right-aligned, with chip-select setup, hold and gap phases around each word.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk_in,
  input  logic        nrst,
  input  logic [31:0] spi_mosi_data,
  input  logic [5:0]  spi_nbits,
  input  logic        spi_request,
  output logic        spi_ready,
  output logic [31:0] spi_miso_data,
  output logic        spi_csn,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    HOLD,
    GAP
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [7:0]  r_divCnt;
  logic [4:0]  r_bitCnt;
  logic [31:0] r_txSr;
  logic [31:0] r_rxSr;
  logic        w_phaseEnd;
  logic [4:0]  w_nbits;

  assign w_phaseEnd = (r_divCnt == 8'(CLK_DIV - 1));
  // Lengths beyond 32 bits saturate at a full word so the bit index stays in range
  assign w_nbits = spi_nbits[5] ? 5'd31 : spi_nbits[4:0];

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (spi_request) w_nextState = SETUP;
      SETUP: if (w_phaseEnd)  w_nextState = LOW;
      LOW:   if (w_phaseEnd)  w_nextState = HIGH;
      HIGH:  if (w_phaseEnd)  w_nextState = (r_bitCnt != 5'd0) ? LOW : HOLD;
      HOLD:  if (w_phaseEnd)  w_nextState = GAP;
      GAP:   if (w_phaseEnd)  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      r_divCnt <= 8'd0;
    end else if (r_state == IDLE || w_phaseEnd) begin
      r_divCnt <= 8'd0;
    end else begin
      r_divCnt <= r_divCnt + 8'd1;
    end
  end

  // Every phase change of the pins happens on the last cycle of the current phase
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      r_bitCnt      <= 5'd0;
      r_txSr        <= 32'd0;
      r_rxSr        <= 32'd0;
      spi_ready     <= 1'b1;
      spi_miso_data <= 32'd0;
      spi_csn       <= 1'b1;
      spi_sclk      <= 1'b1;
      spi_mosi      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (spi_request) begin
            r_txSr    <= spi_mosi_data;
            r_bitCnt  <= w_nbits;
            r_rxSr    <= 32'd0;
            spi_ready <= 1'b0;
            spi_csn   <= 1'b0;
            spi_mosi  <= spi_mosi_data[w_nbits];
          end
        end
        SETUP: begin
          if (w_phaseEnd) spi_sclk <= 1'b0;
        end
        LOW: begin
          if (w_phaseEnd) begin
            spi_sclk <= 1'b1;
            r_rxSr   <= {r_rxSr[30:0], spi_miso};
          end
        end
        HIGH: begin
          if (w_phaseEnd && r_bitCnt != 5'd0) begin
            r_bitCnt <= r_bitCnt - 5'd1;
            spi_mosi <= r_txSr[r_bitCnt - 5'd1];
            spi_sclk <= 1'b0;
          end
        end
        HOLD: begin
          if (w_phaseEnd) begin
            spi_csn       <= 1'b1;
            spi_mosi      <= 1'b0;
            spi_miso_data <= r_rxSr;
          end
        end
        GAP: begin
          if (w_phaseEnd) spi_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
